// File: rtl/sargantana_set_ram_arbiter.sv
// Arbitrates the single-port instruction-cache set RAM between fetch lookups,
// refill writes and an optional full-array invalidate sweep.
//
// Optional feature macro: SARGANTANA_ICACHE_FLUSH_SWEEP_EN
//   defined   : flush_req_i starts an IDLE -> SWEEP -> DONE sweep that writes
//               zero to every entry, one entry per cycle.
//   undefined : no sweep logic; flush_done_o echoes flush_req_i one cycle later.
//
// Ports
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   rd_req_i, rd_addr_i, rd_gnt_o   : lookup request / index / combinational grant
//   rd_valid_o, rd_data_o           : lookup result, one cycle after rd_gnt_o
//   wr_req_i, wr_addr_i, wr_data_i  : refill write request
//   wr_gnt_o                        : combinational refill grant
//   flush_req_i                     : start invalidate sweep
//   flush_busy_o, flush_done_o      : sweep in progress / one-cycle completion
//   ram_req_o, ram_we_o, ram_addr_o,
//   ram_data_o, ram_data_i          : single-port RAM command and read data
module sargantana_set_ram_arbiter #(
  parameter int unsigned ICACHE_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_gnt_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_gnt_o,
  input  logic                  flush_req_i,
  output logic                  flush_busy_o,
  output logic                  flush_done_o,
  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
);

  localparam int unsigned STARVE_W     = 4;
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(4);
  localparam logic [STARVE_W-1:0] STARVE_MAX   = STARVE_W'(15);

  // Depth and address width must describe the same array.
  if (ICACHE_DEPTH != (32'd1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("ICACHE_DEPTH must equal 2**ADDR_WIDTH");
  end

  logic                  sweep_act;   // sweep owns the RAM port this cycle
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  rd_valid_q;

`ifdef SARGANTANA_ICACHE_FLUSH_SWEEP_EN
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_e;

  sweep_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;

  // Sweep state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // Sweep next state; flush requests outside IDLE are dropped.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
        end
      end
      SWEEP: begin
        if (sweep_cnt_q == ADDR_WIDTH'(ICACHE_DEPTH - 1)) begin
          state_d = DONE;
        end else begin
          sweep_cnt_d = sweep_cnt_q + ADDR_WIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sweep_act    = (state_q == SWEEP) && !rst_i;
  assign sweep_addr   = sweep_cnt_q;
  assign flush_busy_o = (state_q == SWEEP);
  assign flush_done_o = (state_q == DONE);
`else
  logic flush_done_q;

  // Without a sweep, a flush completes immediately.
  always_ff @(posedge clk_i) begin
    if (rst_i) flush_done_q <= 1'b0;
    else       flush_done_q <= flush_req_i;
  end

  assign sweep_act    = 1'b0;
  assign sweep_addr   = '0;
  assign flush_busy_o = 1'b0;
  assign flush_done_o = flush_done_q;
`endif

  // Grant selection and RAM command mux: sweep > write > read, with the
  // starvation override letting a long-waiting read beat a write.
  always_comb begin
    rd_gnt_o   = 1'b0;
    wr_gnt_o   = 1'b0;
    ram_req_o  = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (sweep_act) begin
      ram_req_o  = 1'b1;
      ram_we_o   = 1'b1;
      ram_addr_o = sweep_addr;
    end else if (!rst_i) begin
      if (rd_req_i && (!wr_req_i || (starve_q >= STARVE_LIMIT))) begin
        rd_gnt_o   = 1'b1;
        ram_req_o  = 1'b1;
        ram_addr_o = rd_addr_i;
      end else if (wr_req_i) begin
        wr_gnt_o   = 1'b1;
        ram_req_o  = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = wr_addr_i;
        ram_data_o = wr_data_i;
      end
    end
  end

  // Starvation counter: counts denied read cycles, frozen while sweeping.
  always_comb begin
    starve_d = '0;
    if (sweep_act) begin
      starve_d = starve_q;
    end else if (rd_req_i && !rd_gnt_o) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rd_valid_q <= rd_gnt_o;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = ram_data_i;

endmodule

// File: tb/tb_sargantana_set_ram_arbiter.sv
// Scoreboard bench for sargantana_set_ram_arbiter with a behavioural RAM and
// reference model; follows SARGANTANA_ICACHE_FLUSH_SWEEP_EN like the design.
module tb_sargantana_set_ram_arbiter;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          rd_req_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_gnt_o, rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          wr_req_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_gnt_o;
  logic          flush_req_i, flush_busy_o, flush_done_o;
  logic          ram_req_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o, ram_data_i;

  sargantana_set_ram_arbiter #(.ICACHE_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .flush_req_i(flush_req_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Single-port RAM with registered read data.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk_i) begin
    if (ram_req_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
      else          ram_data_i      <= mem[ram_addr_o];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
    logic [AW-1:0] addr;
  } exp_rd_t;

  exp_rd_t       sb[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            wait_cnt  = 0;
  int            sweep_pos = -1;
  bit            done_exp  = 1'b0;
  int unsigned   cyc       = 0;
  int            rd_gnt_at = -1;
  int            n_vec     = 0;
  int            n_miss    = 0;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW+AW+1:0] act, input logic [DW+AW+1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: predict from the arbitration rules, compare, advance model.
  task automatic cycle();
    bit            e_rd, e_wr, e_sw, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    @(negedge clk_i);
    e_busy = (sweep_pos >= 0);
    e_sw   = e_busy && !rst_i;
    e_rd   = 1'b0;
    e_wr   = 1'b0;
    if (!rst_i && !e_busy) begin
      if (rd_req_i && (!wr_req_i || wait_cnt >= 4)) e_rd = 1'b1;
      else if (wr_req_i)                            e_wr = 1'b1;
    end
    e_addr = e_sw ? AW'(sweep_pos) : e_wr ? wr_addr_i : e_rd ? rd_addr_i : '0;
    e_data = e_wr ? wr_data_i : '0;
    if (rd_gnt_o === 1'b1) rd_gnt_at = int'(cyc);
    chk("grant", (DW+AW+2)'({rd_gnt_o, wr_gnt_o, flush_busy_o, flush_done_o}),
                 (DW+AW+2)'({e_rd, e_wr, e_busy, done_exp}));
    chk("ramcmd", {ram_req_o, ram_we_o, ram_addr_o, ram_data_o},
                  {(e_sw | e_rd | e_wr), (e_sw | e_wr), e_addr, e_data});
    if (e_rd) sb.push_back('{ref_mem[rd_addr_i], cyc + 1, rd_addr_i});
    if (e_wr) ref_mem[wr_addr_i] = wr_data_i;
    if (e_sw) ref_mem[sweep_pos] = '0;
    if (rst_i)                     wait_cnt = 0;
    else if (e_busy)               wait_cnt = wait_cnt;
    else if (rd_req_i && !e_rd)    wait_cnt++;
    else                           wait_cnt = 0;
`ifdef SARGANTANA_ICACHE_FLUSH_SWEEP_EN
    if (rst_i) begin
      sweep_pos = -1;
      done_exp  = 1'b0;
    end else if (sweep_pos >= 0) begin
      if (sweep_pos == DEPTH - 1) begin
        sweep_pos = -1;
        done_exp  = 1'b1;
      end else begin
        sweep_pos++;
        done_exp = 1'b0;
      end
    end else begin
      if (flush_req_i && !done_exp) sweep_pos = 0;
      done_exp = 1'b0;
    end
`else
    done_exp = !rst_i && flush_req_i;
`endif
    @(posedge clk_i);
    #1;
    if (e_rd) rd_req_i = 1'b0;
    if (e_wr) wr_req_i = 1'b0;
    flush_req_i = 1'b0;
  endtask

  // Monitor: every rd_valid_o must match the oldest expected lookup, on time.
  initial forever begin
    exp_rd_t e;
    @(negedge clk_i);
    if (rd_valid_o === 1'b1) begin
      n_vec++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        n_miss++;
        $display("FAIL rd_valid_unexpected cyc=%0d: got 1 expected 0", cyc);
      end else begin
        e = sb.pop_front();
        if (rd_data_o !== e.data) begin
          n_miss++;
          $display("FAIL rd_data addr=%0d: got %h expected %h", e.addr, rd_data_o, e.data);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      n_vec++;
      n_miss++;
      e = sb.pop_front();
      $display("FAIL rd_valid_missing addr=%0d: got %b expected 1", e.addr, rd_valid_o);
    end
  end

  initial begin
    int st;
    rst_i = 1'b1; rd_req_i = 1'b1; rd_addr_i = '0; wr_req_i = 1'b1; wr_addr_i = '0;
    wr_data_i = '0; flush_req_i = 1'b1;
    @(posedge clk_i); #1;
    // Reset with everything requesting: no grants, no RAM command.
    repeat (2) begin
      flush_req_i = 1'b1;
      cycle();
    end
    rst_i = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0;
    cycle();

    // Fill every line.
    for (int a = 0; a < DEPTH; a++) begin
      wr_req_i = 1'b1; wr_addr_i = AW'(a); wr_data_i = rand_line();
      cycle();
    end

    // Lone read of line 5.
    rd_req_i = 1'b1; rd_addr_i = AW'(5);
    cycle(); cycle();

    // Same-address read and write: write first, read sees the new line.
    rd_req_i = 1'b1; rd_addr_i = AW'(9);
    wr_req_i = 1'b1; wr_addr_i = AW'(9); wr_data_i = rand_line();
    repeat (3) cycle();

    // Continuous writes starve a read until its fifth waiting cycle.
    rd_req_i = 1'b1; rd_addr_i = AW'($urandom_range(DEPTH - 1));
    rd_gnt_at = -1;
    st = int'(cyc);
    for (int k = 0; k < 10; k++) begin
      if (!wr_req_i) begin
        wr_req_i = 1'b1; wr_addr_i = AW'($urandom_range(DEPTH - 1)); wr_data_i = rand_line();
      end
      cycle();
    end
    wr_req_i = 1'b0;
    n_vec++;
    if (rd_gnt_at != st + 4) begin
      n_miss++;
      $display("FAIL starve_grant_cycle: got %0d expected %0d", rd_gnt_at - st + 1, 5);
    end
    cycle();

    // Flush pulse with a read granted in the same cycle, then read back.
    flush_req_i = 1'b1; rd_req_i = 1'b1; rd_addr_i = AW'(3);
    cycle();
    repeat (DEPTH + 3) cycle();
    for (int a = 0; a < 4; a++) begin
      rd_req_i = 1'b1; rd_addr_i = (a == 3) ? AW'(DEPTH - 1) : AW'(a * 17);
      cycle();
    end

`ifdef SARGANTANA_ICACHE_FLUSH_SWEEP_EN
    // Reset at sweep cycle 20 abandons the sweep.
    flush_req_i = 1'b1;
    cycle();
    repeat (20) cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    rd_req_i = 1'b1; rd_addr_i = AW'(2);
    repeat (3) cycle();
`endif

    // Randomised traffic with withdrawals, flushes and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (!rd_req_i && ($urandom_range(1) == 1)) begin
        rd_req_i = 1'b1; rd_addr_i = AW'($urandom_range(DEPTH - 1));
      end else if (rd_req_i && ($urandom_range(15) == 0)) begin
        rd_req_i = 1'b0;
      end
      if (!wr_req_i && ($urandom_range(2) == 0)) begin
        wr_req_i = 1'b1; wr_addr_i = AW'($urandom_range(DEPTH - 1)); wr_data_i = rand_line();
      end
      flush_req_i = ($urandom_range(99) == 0);
      rst_i = ($urandom_range(299) == 0);
      cycle();
    end
    rst_i = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0;
    repeat (DEPTH + 4) cycle();

    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sargantana_set_ram_arbiter.md
SARGANTANA_SET_RAM_ARBITER -- requirements
Module: sargantana_set_ram_arbiter

Interface
REQ-001 Parameter ICACHE_DEPTH, default 64, number of set RAM entries (power of two, >=2).
REQ-002 Parameter ADDR_WIDTH, default 6, set RAM address width, equals log2(ICACHE_DEPTH).
REQ-003 Parameter DATA_WIDTH, default 256, set RAM line width in bits.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 rd_req_i  in  1, rd_addr_i  in  ADDR_WIDTH: fetch lookup request and index.
REQ-007 rd_gnt_o  out  1: lookup accepted this cycle.
REQ-008 rd_valid_o  out  1, rd_data_o  out  DATA_WIDTH: lookup result.
REQ-009 wr_req_i  in  1, wr_addr_i  in  ADDR_WIDTH, wr_data_i  in  DATA_WIDTH: refill write.
REQ-010 wr_gnt_o  out  1: refill write accepted this cycle.
REQ-011 flush_req_i  in  1: start full-array invalidate sweep.
REQ-012 flush_busy_o  out  1: sweep in progress; flush_done_o  out  1: one-cycle completion pulse.
REQ-013 ram_req_o  out  1, ram_we_o  out  1, ram_addr_o  out  ADDR_WIDTH, ram_data_o  out  DATA_WIDTH: single-port RAM command.
REQ-014 ram_data_i  in  DATA_WIDTH: RAM read data, registered inside RAM, valid one cycle after a read command.

Function
REQ-015 Grants are combinational from current requests and state; at most one of rd_gnt_o, wr_gnt_o, sweep write per cycle.
REQ-016 Requesters hold req and address/data stable until granted; a deasserted req without grant is a withdrawn request.
REQ-017 Priority: sweep > write > read, except starvation override (REQ-018).
REQ-018 4-bit starvation counter increments each cycle rd_req_i=1 and rd_gnt_o=0, clears on rd_gnt_o or rd_req_i=0; at value 4 read beats write (never beats sweep).
REQ-019 Read grant: ram_req_o=1, ram_we_o=0, ram_addr_o=rd_addr_i; rd_valid_o=1 exactly the next cycle; rd_data_o=ram_data_i (pass-through).
REQ-020 Write grant: ram_req_o=1, ram_we_o=1, ram_addr_o=wr_addr_i, ram_data_o=wr_data_i.
REQ-021 No grant: ram_req_o=0; ram_we_o, ram_addr_o, ram_data_o drive 0.
REQ-022 Same-address read and write pending simultaneously with no override: write granted, read waits (read returns new data).
REQ-023 Sweep FSM states IDLE, SWEEP, DONE; IDLE->SWEEP on flush_req_i=1, sweep counter loaded 0.
REQ-024 SWEEP: each cycle ram_req_o=1, ram_we_o=1, ram_addr_o=counter, ram_data_o=0, counter+1; flush_busy_o=1.
REQ-025 SWEEP->DONE after writing address ICACHE_DEPTH-1 (no counter wrap); sweep takes exactly ICACHE_DEPTH cycles.
REQ-026 DONE: flush_done_o=1 one cycle, array port free for normal arbitration that cycle, then ->IDLE.
REQ-027 flush_req_i in SWEEP or DONE ignored (no restart, no queuing).
REQ-028 Read granted in the cycle before SWEEP entry still produces rd_valid_o next cycle.
REQ-029 Starvation counter holds (no increment) during SWEEP.

Reset
REQ-030 rst_i=1 at any edge: FSM->IDLE, sweep counter=0, starvation counter=0, rd_valid_o=0, flush_busy_o=0, flush_done_o=0.
REQ-031 While rst_i=1 all grants and ram_req_o are 0; reset mid-sweep abandons sweep without flush_done_o.

Configuration
REQ-032 Macro SARGANTANA_ICACHE_FLUSH_SWEEP_EN defined: sweep FSM per REQ-023..REQ-029 present.
REQ-033 Macro undefined: no sweep logic; flush_req_i ignored; flush_busy_o=0; flush_done_o driven 1 the cycle after flush_req_i=1 (pulse per request cycle).

Verification
REQ-034 rd_req_i=1, rd_addr_i=5 alone -> rd_gnt_o=1, RAM read addr 5; next cycle rd_valid_o=1, rd_data_o=stored line 5.
REQ-035 rd_req_i and wr_req_i both held, addr 9 -> write granted first, read next cycle returns wr_data_i.
REQ-036 wr_req_i held continuously, rd_req_i held -> read granted on 5th cycle of waiting, then writes resume.
REQ-037 Write all 64 lines, flush_req_i pulse -> flush_busy_o 64 cycles, addrs 0..63 written 0, flush_done_o pulse, reads return 0.
REQ-038 rst_i asserted at sweep cycle 20 -> next cycle flush_busy_o=0, no flush_done_o, normal arbitration resumes.
REQ-039 Macro undefined, flush_req_i pulse -> no RAM writes, flush_done_o=1 next cycle.
